button_conditioner: RTL

Multi-channel push-button conditioner that sits directly upstream of the board-level LED/switch test logic and the snake game's direction/start control. Each raw, asynchronous, bouncy button input is synchronised, debounced by a per-channel state machine, and delivered as a clean level plus single-cycle press and release strobes. Downstream logic consumes `btn_press` directly and needs no edge detection of its own.

---
 rtl/button_conditioner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-FF synchroniser, debounce FSM and
// registered level / press / release outputs for N_BTN push-buttons.
// Optional feature macro: BTN_AUTOREPEAT_EN adds auto-repeat press strobes
// while a button stays held.
//
// Handshake: there is no valid/ready handshake. btn_press and btn_release
// are one-cycle strobes that downstream logic samples on every clock;
// btn_level is a steady debounced level.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  logic [N_BTN-1:0] norm;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  // Normalise polarity so that 1 always means pressed.
  always_comb begin
    norm = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  end

  // Two-stage synchroniser; reset value is the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [1:0]    state;     // debug-visible FSM state for this channel
    logic [CW-1:0] cnt;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          s;
`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] rpt;
    logic          rpt_periodic;  // first repeat already issued
`endif

    assign s = sync2[g];

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt          <= '0;
        rpt_periodic <= 1'b0;
`endif
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state)
          IDLE: begin
            if (s) begin
              state <= PRESS_CHK;
              cnt   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s) begin
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              state   <= HELD;
              level_r <= 1'b1;
              press_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rpt          <= '0;
              rpt_periodic <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!s) begin
              state <= RELEASE_CHK;
              cnt   <= '0;
            end else begin
`ifdef BTN_AUTOREPEAT_EN
              // Repeat counter only advances while the button sits in HELD.
              if (rpt == (rpt_periodic ? PERIOD_LAST : DELAY_LAST)) begin
                press_r      <= 1'b1;
                rpt          <= '0;
                rpt_periodic <= 1'b1;
              end else begin
                rpt <= rpt + 1'b1;
              end
`endif
            end
          end
          RELEASE_CHK: begin
            if (s) begin
              state <= HELD;
            end else if (cnt == CNT_LAST) begin
              state     <= IDLE;
              level_r   <= 1'b0;
              release_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rpt          <= '0;
              rpt_periodic <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign btn_level[g]   = level_r;
    assign btn_press[g]   = press_r;
    assign btn_release[g] = release_r;
  end

endmodule
